video_capture: RTL and testbench

- Receive end of the 1-bit TRS-80 video interface: samples an external monochrome pixel stream with HSYNC/VSYNC (native M1 timing, ~10.6445 MHz dot rate).
- Reconstructs the 384x192 active raster and packs 8 pixels per byte, MSB = leftmost.
- Emits byte writes into a frame-buffer write port (dual-port RAM owned by the instantiating top level).
- Sits beside the VGA generator so captured or forwarded M1 video can be displayed or inspected.

---
 rtl/video_pkg.sv | 22 ++
 rtl/sync_edge.sv | 29 ++
 rtl/video_capture.sv | 238 +++++++++++++++++++++++
 tb/tb_video_capture.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and default M1 video timing for capture and VGA paths
package video_pkg;

    typedef enum logic [2:0] {
        WAIT_V,
        SKIP,
        HDLY,
        CAP,
        LDONE
    } cap_state_e;

    localparam int FB_AW = 14;

    localparam logic [15:0] M1_PHASE_INC      = 16'd6976;
    localparam logic [12:0] M1_H_START        = 13'd1150;
    localparam logic [5:0]  M1_V_START        = 6'd40;
    localparam logic [7:0]  M1_ACT_LINES      = 8'd192;
    localparam logic [5:0]  M1_BYTES_PER_LINE = 6'd48;
    localparam logic [12:0] M1_H_PERIOD_MIN   = 13'd6300;
    localparam logic [12:0] M1_H_PERIOD_MAX   = 13'd6500;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchroniser with a rising-edge pulse on the synchronised level
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [2:0] sh_q;
    logic [2:0] sh_d;

    always_comb begin
        sh_d = {sh_q[1:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    // Bit 2 only remembers the previous synchronised level for edge detection.
    assign dout = sh_q[1];
    assign rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/video_capture.sv
// rtl/video_capture.sv - recovers the 1-bit M1 raster and writes packed pixel bytes to a frame buffer
module video_capture
    import video_pkg::*;
#(
    parameter logic [15:0] PHASE_INC      = M1_PHASE_INC,
    parameter logic [12:0] H_START        = M1_H_START,
    parameter logic [5:0]  V_START        = M1_V_START,
    parameter logic [7:0]  ACT_LINES      = M1_ACT_LINES,
    parameter logic [5:0]  BYTES_PER_LINE = M1_BYTES_PER_LINE,
    parameter logic [12:0] H_PERIOD_MIN   = M1_H_PERIOD_MIN,
    parameter logic [12:0] H_PERIOD_MAX   = M1_H_PERIOD_MAX
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             VID_PIX,
    input  logic             VID_HSYNC,
    input  logic             VID_VSYNC,
    output logic             FB_WE,
    output logic [FB_AW-1:0] FB_ADDR,
    output logic [7:0]       FB_DATA,
    output logic             LOCKED,
    output logic             FRAME_TGL,
    output logic [7:0]       ERR_CNT
);

    logic pix, pix_rise, hs_lvl, hs_rise, vs_lvl, vs_rise;

    sync_edge u_sync_pix (.clk(clk), .rst_n(reset_n), .din(VID_PIX),   .dout(pix),    .rise(pix_rise));
    sync_edge u_sync_hs  (.clk(clk), .rst_n(reset_n), .din(VID_HSYNC), .dout(hs_lvl), .rise(hs_rise));
    sync_edge u_sync_vs  (.clk(clk), .rst_n(reset_n), .din(VID_VSYNC), .dout(vs_lvl), .rise(vs_rise));

    logic unused_sync;
    assign unused_sync = &{1'b0, pix_rise, hs_lvl, vs_lvl};

    cap_state_e       state_q, state_d;
    logic [12:0]      dly_q, dly_d;
    logic [15:0]      acc_q, acc_d;
    logic [7:0]       sh_q, sh_d;
    logic [2:0]       bit_q, bit_d;
    logic [5:0]       byte_q, byte_d;
    logic [5:0]       vline_q, vline_d;
    logic [7:0]       line_q, line_d;
    logic [FB_AW-1:0] base_q, base_d;
    logic [12:0]      hcnt_q, hcnt_d;
    logic             have_h_q, have_h_d;
    logic             frame_err_q, frame_err_d;
    logic             fb_we_q, fb_we_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]       fb_data_q, fb_data_d;
    logic             locked_q, locked_d;
    logic             frame_tgl_q, frame_tgl_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [16:0]      acc_sum;
    logic [13:0]      h_period;
    logic             h_bad;
    logic [7:0]       line_inc;
    logic [FB_AW-1:0] base_inc;
    logic             err_fsm, err_now, frame_done;

    assign acc_sum  = {1'b0, acc_q} + {1'b0, PHASE_INC};
    assign h_period = {1'b0, hcnt_q} + 14'd1;
    assign h_bad    = hs_rise & (~have_h_q | (h_period < {1'b0, H_PERIOD_MIN})
                                           | (h_period > {1'b0, H_PERIOD_MAX}));
    assign line_inc = line_q + 8'd1;
    assign base_inc = base_q + {8'd0, BYTES_PER_LINE};

    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        acc_d       = acc_q;
        sh_d        = sh_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        vline_d     = vline_q;
        line_d      = line_q;
        base_d      = base_q;
        hcnt_d      = hcnt_q;
        have_h_d    = have_h_q;
        frame_err_d = frame_err_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        locked_d    = locked_q;
        frame_tgl_d = frame_tgl_q;
        err_cnt_d   = err_cnt_q;
        err_fsm     = 1'b0;
        frame_done  = 1'b0;

        // Counter reads (period - 1) at the next edge, hence the +1 in h_period.
        if (hs_rise) begin
            hcnt_d   = '0;
            have_h_d = 1'b1;
        end else if (hcnt_q != '1) begin
            hcnt_d = hcnt_q + 13'd1;
        end

        if (vs_rise) begin
            err_fsm = (state_q != WAIT_V);
            state_d = SKIP;
            vline_d = '0;
        end else begin
            case (state_q)
                WAIT_V: ;
                SKIP: begin
                    if (hs_rise) begin
                        if (vline_q == V_START - 6'd1) begin
                            state_d = HDLY;
                            line_d  = '0;
                            base_d  = '0;
                            dly_d   = '0;
                        end else begin
                            vline_d = vline_q + 6'd1;
                        end
                    end
                end
                HDLY: begin
                    if (hs_rise) begin
                        dly_d = '0;
                    end else if (dly_q == H_START - 13'd1) begin
                        state_d = CAP;
                        acc_d   = 16'h8000;
                        sh_d    = '0;
                        bit_d   = '0;
                        byte_d  = '0;
                    end else begin
                        dly_d = dly_q + 13'd1;
                    end
                end
                CAP: begin
                    if (hs_rise) begin
                        // Early HSYNC: abandon the rest of the line and start the next from this edge.
                        err_fsm = (byte_q != BYTES_PER_LINE);
                        line_d  = line_inc;
                        base_d  = base_inc;
                        dly_d   = '0;
                        if (line_inc == ACT_LINES) begin
                            frame_done = 1'b1;
                            state_d    = WAIT_V;
                        end else begin
                            state_d = HDLY;
                        end
                    end else if (byte_q == BYTES_PER_LINE) begin
                        line_d  = line_inc;
                        base_d  = base_inc;
                        state_d = LDONE;
                    end else begin
                        acc_d = acc_sum[15:0];
                        if (acc_sum[16]) begin
                            sh_d  = {sh_q[6:0], pix};
                            bit_d = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                fb_we_d   = 1'b1;
                                fb_addr_d = base_q + {8'd0, byte_q};
                                fb_data_d = {sh_q[6:0], pix};
                                byte_d    = byte_q + 6'd1;
                            end
                        end
                    end
                end
                LDONE: begin
                    if (line_q == ACT_LINES) begin
                        frame_done = 1'b1;
                        state_d    = WAIT_V;
                    end else if (hs_rise) begin
                        state_d = HDLY;
                        dly_d   = '0;
                    end
                end
                default: state_d = WAIT_V;
            endcase
        end

        err_now     = err_fsm | h_bad;
        frame_err_d = frame_err_q | err_now;
        if (err_now) begin
            locked_d = 1'b0;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
        if (frame_done) begin
            frame_tgl_d = ~frame_tgl_q;
            locked_d    = ~(frame_err_q | err_now);
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_V;
            dly_q       <= '0;
            acc_q       <= '0;
            sh_q        <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            vline_q     <= '0;
            line_q      <= '0;
            base_q      <= '0;
            hcnt_q      <= '0;
            have_h_q    <= 1'b0;
            frame_err_q <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            locked_q    <= 1'b0;
            frame_tgl_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            acc_q       <= acc_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            vline_q     <= vline_d;
            line_q      <= line_d;
            base_q      <= base_d;
            hcnt_q      <= hcnt_d;
            have_h_q    <= have_h_d;
            frame_err_q <= frame_err_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            locked_q    <= locked_d;
            frame_tgl_q <= frame_tgl_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign FB_WE     = fb_we_q;
    assign FB_ADDR   = fb_addr_q;
    assign FB_DATA   = fb_data_q;
    assign LOCKED    = locked_q;
    assign FRAME_TGL = frame_tgl_q;
    assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_video_capture.sv
// tb/tb_video_capture.sv - frame-level bench for video_capture on a compressed timing (2 clks per dot)
module tb_video_capture;

    localparam int H   = 20;
    localparam int BPL = 48;
    localparam int NL  = 12;
    localparam int LP  = 800;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        VID_PIX = 1'b0;
    logic        VID_HSYNC = 1'b0;
    logic        VID_VSYNC = 1'b0;
    logic        FB_WE;
    logic [13:0] FB_ADDR;
    logic [7:0]  FB_DATA;
    logic        LOCKED;
    logic        FRAME_TGL;
    logic [7:0]  ERR_CNT;

    always #5 clk = ~clk;

    video_capture #(
        .PHASE_INC      (16'd32768),
        .H_START        (13'd20),
        .V_START        (6'd2),
        .ACT_LINES      (8'd12),
        .BYTES_PER_LINE (6'd48),
        .H_PERIOD_MIN   (13'd780),
        .H_PERIOD_MAX   (13'd820)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .VID_PIX   (VID_PIX),
        .VID_HSYNC (VID_HSYNC),
        .VID_VSYNC (VID_VSYNC),
        .FB_WE     (FB_WE),
        .FB_ADDR   (FB_ADDR),
        .FB_DATA   (FB_DATA),
        .LOCKED    (LOCKED),
        .FRAME_TGL (FRAME_TGL),
        .ERR_CNT   (ERR_CNT)
    );

    int n_checks = 0;
    int n_errors = 0;
    int q_addr[$];
    logic [7:0] q_data[$];

    always @(negedge clk) begin
        if (FB_WE) begin
            q_addr.push_back(int'(FB_ADDR));
            q_data.push_back(FB_DATA);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic pix_of(input int pat, input int line, input int dot);
        if (pat == 0) return (dot % 2) == 0;
        return (line == 5) && (dot == 9);
    endfunction

    function automatic logic [7:0] exp_byte(input int pat, input int addr);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[7-b] = pix_of(pat, addr / BPL, (addr % BPL) * 8 + b);
        return r;
    endfunction

    // Cycle c of a line is the pin value sampled at the c-th posedge after the HSYNC pin rise.
    task automatic drive_line(input int period, input int line, input int vs_at, input int pat);
        for (int c = 0; c < period; c++) begin
            @(negedge clk);
            VID_HSYNC = (c < 8);
            VID_VSYNC = (vs_at >= 0) && (c >= vs_at) && (c < vs_at + 8);
            VID_PIX   = (line >= 0 && c >= H && (c - H) / 2 < 384) ? pix_of(pat, line, (c - H) / 2) : 1'b0;
        end
    endtask

    task automatic drive_frame(input int pat, input int short_l, input int long_l);
        drive_line(LP, -1, 100, pat);
        drive_line(LP, -1, -1, pat);
        for (int l = 0; l < NL; l++)
            drive_line((l == short_l) ? 345 : (l == long_l) ? 900 : LP, l, -1, pat);
    endtask

    task automatic analyse(input int from, input int pat, output int n, output int first,
                           output int last, output int inr, output int a499, output int bad);
        n = 0; first = -1; last = -1; inr = 0; a499 = -1; bad = 0;
        for (int i = from; i < q_addr.size(); i++) begin
            if (n == 0) first = q_addr[i];
            if (i > from && q_addr[i-1] == 499 && a499 < 0) a499 = q_addr[i];
            last = q_addr[i];
            n++;
            if (q_addr[i] >= 500 && q_addr[i] <= 527) inr++;
            if (q_data[i] != exp_byte(pat, q_addr[i])) bad++;
        end
    endtask

    typedef struct {
        int pat;
        int short_l;
        int long_l;
        int writes;
        int last;
        int err;
        int locked;
        int tgl;
        int inr;
        int a499;
    } row_t;

    row_t rows[4];

    initial begin
        int from, n, first, last, inr, a499, bad;

        rows[0] = '{0, -1, -1, 576, 575, 1, 0, 1, 28, 500};
        rows[1] = '{0, -1, -1, 576, 575, 1, 1, 0, 28, 500};
        rows[2] = '{0, 10, -1, 548, 575, 2, 0, 1, 0, 528};
        rows[3] = '{1, -1, 7, 576, 575, 3, 0, 0, 28, 500};

        repeat (3) @(negedge clk);
        check("rst_we", int'(FB_WE), 0);
        check("rst_addr", int'(FB_ADDR), 0);
        check("rst_data", int'(FB_DATA), 0);
        check("rst_locked", int'(LOCKED), 0);
        check("rst_tgl", int'(FRAME_TGL), 0);
        check("rst_err", int'(ERR_CNT), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            from = q_addr.size();
            drive_frame(rows[i].pat, rows[i].short_l, rows[i].long_l);
            analyse(from, rows[i].pat, n, first, last, inr, a499, bad);
            check($sformatf("r%0d_writes", i), n, rows[i].writes);
            check($sformatf("r%0d_first", i), first, 0);
            check($sformatf("r%0d_last", i), last, rows[i].last);
            check($sformatf("r%0d_baddata", i), bad, 0);
            check($sformatf("r%0d_inrange", i), inr, rows[i].inr);
            check($sformatf("r%0d_after499", i), a499, rows[i].a499);
            check($sformatf("r%0d_err", i), int'(ERR_CNT), rows[i].err);
            check($sformatf("r%0d_locked", i), int'(LOCKED), rows[i].locked);
            check($sformatf("r%0d_tgl", i), int'(FRAME_TGL), rows[i].tgl);
        end

        // VSYNC arriving while line 6 is being captured.
        drive_line(LP, -1, 100, 0);
        drive_line(LP, -1, -1, 0);
        for (int l = 0; l < 6; l++) drive_line(LP, l, -1, 0);
        drive_line(LP, 6, 200, 0);
        check("vabort_err", int'(ERR_CNT), 4);
        check("vabort_locked", int'(LOCKED), 0);
        check("vabort_tgl", int'(FRAME_TGL), 0);
        from = q_addr.size();
        drive_line(LP, -1, -1, 0);
        drive_line(LP, 0, -1, 0);
        drive_line(LP, 1, -1, 0);
        analyse(from, 0, n, first, last, inr, a499, bad);
        check("vabort_writes", n, 96);
        check("vabort_first", first, 0);
        check("vabort_last", last, 95);
        check("vabort_baddata", bad, 0);

        // Asynchronous reset pulse in the middle of capturing line 2.
        fork
            drive_line(LP, 2, -1, 0);
            begin
                repeat (300) @(negedge clk);
                #2 reset_n = 1'b0;
                #1;
                check("mrst_we", int'(FB_WE), 0);
                check("mrst_addr", int'(FB_ADDR), 0);
                check("mrst_data", int'(FB_DATA), 0);
                check("mrst_locked", int'(LOCKED), 0);
                check("mrst_tgl", int'(FRAME_TGL), 0);
                check("mrst_err", int'(ERR_CNT), 0);
                repeat (3) @(posedge clk);
                #2 reset_n = 1'b1;
            end
        join
        from = q_addr.size();
        drive_line(LP, 3, -1, 0);
        drive_line(LP, 4, -1, 0);
        analyse(from, 0, n, first, last, inr, a499, bad);
        check("mrst_nowrites", n, 0);
        from = q_addr.size();
        drive_line(LP, -1, 100, 0);
        drive_line(LP, -1, -1, 0);
        drive_line(LP, 0, -1, 0);
        analyse(from, 0, n, first, last, inr, a499, bad);
        check("mrst_writes", n, 48);
        check("mrst_first", first, 0);
        check("mrst_last", last, 47);
        check("mrst_baddata", bad, 0);
        check("mrst_err_after", int'(ERR_CNT), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
